// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST engine.
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int         NUM_ELEM  = 6;
    localparam logic [2:0] LAST_ELEM = 3'(NUM_ELEM - 1);

    // One March element: direction, one or two ops, op0 may be a read,
    // op1 (when present) is always a write. *_one selects all-ones data.
    typedef struct packed {
        logic down;
        logic two_ops;
        logic op0_rd;
        logic op0_one;
        logic op1_one;
    } elem_t;

    // March C-: E0 up(w0) E1 up(r0,w1) E2 up(r1,w0) E3 dn(r0,w1) E4 dn(r1,w0) E5 up(r0)
    function automatic elem_t elem_info(input logic [2:0] e);
        elem_t r;
        case (e)
            3'd0:    r = '{down: 1'b0, two_ops: 1'b0, op0_rd: 1'b0, op0_one: 1'b0, op1_one: 1'b0};
            3'd1:    r = '{down: 1'b0, two_ops: 1'b1, op0_rd: 1'b1, op0_one: 1'b0, op1_one: 1'b1};
            3'd2:    r = '{down: 1'b0, two_ops: 1'b1, op0_rd: 1'b1, op0_one: 1'b1, op1_one: 1'b0};
            3'd3:    r = '{down: 1'b1, two_ops: 1'b1, op0_rd: 1'b1, op0_one: 1'b0, op1_one: 1'b1};
            3'd4:    r = '{down: 1'b1, two_ops: 1'b1, op0_rd: 1'b1, op0_one: 1'b1, op1_one: 1'b0};
            3'd5:    r = '{down: 1'b0, two_ops: 1'b0, op0_rd: 1'b1, op0_one: 1'b0, op1_one: 1'b0};
            default: r = '{down: 1'b0, two_ops: 1'b0, op0_rd: 1'b0, op0_one: 1'b0, op1_one: 1'b0};
        endcase
        return r;
    endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter with start-address load and last-address flag.
module sram_bist_addr_gen #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              load_down,
    input  logic              step,
    input  logic              down,
    output logic [ADDR_W-1:0] addr,
    output logic              last
);
    localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

    // Load selects 0 or N-1 by direction; step moves one word the current way.
    always_ff @(posedge clk) begin
        if (rst)
            addr <= '0;
        else if (load)
            addr <= load_down ? '1 : '0;
        else if (step)
            addr <= down ? addr - ONE : addr + ONE;
    end

    assign last = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_march_bist.sv
// March C- BIST engine driving the BIST port of a 1P SRAM macro.
module sram_march_bist
    import sram_bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [CNT_W-1:0]  fail_cnt,
    output logic [ADDR_W-1:0] fail_addr,
    output logic [DATA_W-1:0] fail_bits,
    output logic              bist_en,
    output logic              bist_men,
    output logic              bist_wen,
    output logic              bist_ren,
    output logic [ADDR_W-1:0] bist_addr,
    output logic [DATA_W-1:0] bist_din,
    output logic [DATA_W-1:0] bist_bm,
    input  logic [DATA_W-1:0] sram_dout
);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    state_t            state, state_nxt;
    logic [2:0]        elem;
    logic              op;
    elem_t             info, info_nxt;
    logic              op_last, cur_rd, cur_one, run, start_run;
    logic              ag_load, ag_load_down, ag_step, ag_last;
    logic [ADDR_W-1:0] ag_addr;
    logic              rd_pend;
    logic [DATA_W-1:0] exp_data;
    logic [ADDR_W-1:0] rd_addr;

    assign info      = elem_info(elem);
    assign info_nxt  = elem_info(elem + 3'd1);
    assign op_last   = op || !info.two_ops;
    assign cur_rd    = !op && info.op0_rd;
    assign cur_one   = op ? info.op1_one : info.op0_one;
    assign run       = (state == ST_RUN);
    assign start_run = start && (state == ST_IDLE || state == ST_DONE);
    assign bist_bm   = '1;

    sram_bist_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .clk       (clk),
        .rst       (rst),
        .load      (ag_load),
        .load_down (ag_load_down),
        .step      (ag_step),
        .down      (info.down),
        .addr      (ag_addr),
        .last      (ag_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // Next state, address-generator control and BIST port drive.
    always_comb begin
        state_nxt    = state;
        ag_load      = 1'b0;
        ag_load_down = 1'b0;
        ag_step      = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;
        bist_en      = 1'b0;
        bist_men     = 1'b0;
        bist_wen     = 1'b0;
        bist_ren     = 1'b0;
        bist_addr    = '0;
        bist_din     = '0;
        case (state)
            ST_IDLE, ST_DONE: begin
                done = (state == ST_DONE);
                if (start) begin
                    state_nxt = ST_RUN;
                    ag_load   = 1'b1;
                end
            end
            ST_RUN: begin
                busy      = 1'b1;
                bist_en   = 1'b1;
                bist_men  = 1'b1;
                bist_wen  = !cur_rd;
                bist_ren  = cur_rd;
                bist_addr = ag_addr;
                bist_din  = {DATA_W{cur_one}};
                if (op_last) begin
                    if (!ag_last) begin
                        ag_step = 1'b1;
                    end else if (elem == LAST_ELEM) begin
                        state_nxt = ST_DRAIN;
                    end else begin
                        // Next element starts on the following cycle, no bubble.
                        ag_load      = 1'b1;
                        ag_load_down = info_nxt.down;
                    end
                end
            end
            ST_DRAIN: begin
                busy      = 1'b1;
                bist_en   = 1'b1;
                state_nxt = ST_DONE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Only a clean run reports pass; output stays low outside DONE.
    always_comb begin
        pass = (state == ST_DONE) && (fail_cnt == '0);
    end

    // Element/op sequencing, read-compare pipeline and failure log.
    always_ff @(posedge clk) begin
        if (rst) begin
            elem      <= '0;
            op        <= 1'b0;
            rd_pend   <= 1'b0;
            exp_data  <= '0;
            rd_addr   <= '0;
            fail_cnt  <= '0;
            fail_addr <= '0;
            fail_bits <= '0;
        end else begin
            // Macro returns read data one cycle later; remember what to expect.
            rd_pend  <= run && cur_rd;
            exp_data <= {DATA_W{cur_one}};
            rd_addr  <= ag_addr;
            if (start_run) begin
                elem      <= '0;
                op        <= 1'b0;
                fail_cnt  <= '0;
                fail_addr <= '0;
                fail_bits <= '0;
            end else begin
                if (rd_pend && (sram_dout != exp_data)) begin
                    if (fail_cnt == '0) begin
                        fail_addr <= rd_addr;
                        fail_bits <= sram_dout ^ exp_data;
                    end
                    if (fail_cnt != '1)
                        fail_cnt <= fail_cnt + CNT_ONE;
                end
                if (run) begin
                    if (!op_last) begin
                        op <= 1'b1;
                    end else begin
                        op <= 1'b0;
                        if (ag_last && elem != LAST_ELEM)
                            elem <= elem + 3'd1;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_march_bist.sv
// Self-checking bench: behavioural SRAM with stuck-at faults, March C-
// reference computed from a textual element table, randomized fault runs.
module tb_sram_march_bist;
    localparam int ADDR_W = 8;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 16;
    localparam int N      = 1 << ADDR_W;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic              busy, done, pass;
    logic [CNT_W-1:0]  fail_cnt;
    logic [ADDR_W-1:0] fail_addr;
    logic [DATA_W-1:0] fail_bits;
    logic              bist_en, bist_men, bist_wen, bist_ren;
    logic [ADDR_W-1:0] bist_addr;
    logic [DATA_W-1:0] bist_din, bist_bm;
    logic [DATA_W-1:0] sram_dout;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    sram_march_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .start(start),
        .busy(busy), .done(done), .pass(pass),
        .fail_cnt(fail_cnt), .fail_addr(fail_addr), .fail_bits(fail_bits),
        .bist_en(bist_en), .bist_men(bist_men), .bist_wen(bist_wen), .bist_ren(bist_ren),
        .bist_addr(bist_addr), .bist_din(bist_din), .bist_bm(bist_bm),
        .sram_dout(sram_dout)
    );

    // Fault maps (written only by the stimulus process).
    logic [DATA_W-1:0] sa1m [N];
    logic [DATA_W-1:0] sa0m [N];
    logic [DATA_W-1:0] mem  [N];

    function automatic logic [DATA_W-1:0] faulty(input logic [DATA_W-1:0] v, input int a);
        return (v | sa1m[a]) & ~sa0m[a];
    endfunction

    function automatic int pack_op(input bit w, input bit r, input int a, input logic [DATA_W-1:0] d);
        logic [7:0] a8;
        a8 = a[7:0];
        return int'({w, r, a8, d});
    endfunction

    // Behavioural macro: 1-cycle read latency, byte-masked writes.
    always @(posedge clk) begin
        if (bist_en && bist_men) begin
            if (bist_wen) mem[bist_addr] <= (mem[bist_addr] & ~bist_bm) | (bist_din & bist_bm);
            if (bist_ren) sram_dout <= faulty(mem[bist_addr], int'(bist_addr));
        end
    end

    // Operation trace seen on the BIST port.
    int act_q[$];
    always @(negedge clk) begin
        if (bist_men) act_q.push_back(pack_op(bist_wen, bist_ren, int'(bist_addr), bist_din));
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    string march [6];
    bit    march_down [6];
    int    exp_q[$];

    // Reference: walk the March table over an ideal memory with the same faults.
    task automatic ref_run(output int cnt, output logic [ADDR_W-1:0] faddr, output logic [DATA_W-1:0] fbits);
        logic [DATA_W-1:0] m [N];
        logic [DATA_W-1:0] d, got;
        int a;
        cnt = 0; faddr = '0; fbits = '0;
        exp_q.delete();
        for (int i = 0; i < N; i++) m[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int j = 0; j < N; j++) begin
                a = march_down[e] ? N - 1 - j : j;
                for (int o = 0; o < march[e].len() / 2; o++) begin
                    d = (march[e].getc(2*o+1) == "1") ? '1 : '0;
                    if (march[e].getc(2*o) == "w") begin
                        exp_q.push_back(pack_op(1'b1, 1'b0, a, d));
                        m[a] = d;
                    end else begin
                        exp_q.push_back(pack_op(1'b0, 1'b1, a, d));
                        got = faulty(m[a], a);
                        if (got != d) begin
                            if (cnt == 0) begin faddr = a[ADDR_W-1:0]; fbits = got ^ d; end
                            if (cnt < 65535) cnt++;
                        end
                    end
                end
            end
        end
    endtask

    task automatic clear_faults();
        for (int i = 0; i < N; i++) begin sa1m[i] = '0; sa0m[i] = '0; end
    endtask

    // One full run; start held high for 'hold' edges after the start edge.
    task automatic run_test(input string nm, input int hold);
        int ecnt, n, idx0, mism, nw, nr, alen;
        logic [ADDR_W-1:0] eaddr;
        logic [DATA_W-1:0] ebits;
        logic [CNT_W-1:0]  cnt_snap;
        ref_run(ecnt, eaddr, ebits);
        idx0 = act_q.size();
        @(negedge clk); start = 1'b1;
        @(posedge clk); n = 0;
        @(negedge clk);
        chk({nm, "_clr_done"}, 32'(done), 32'd0);
        chk({nm, "_clr_cnt"}, 32'(fail_cnt), 32'd0);
        chk({nm, "_busy"}, 32'(busy), 32'd1);
        while (!done && n < 3000) begin
            if (n >= hold) start = 1'b0;
            if (n == 10 * N) begin
                chk({nm, "_drain_men"}, 32'(bist_men), 32'd0);
                chk({nm, "_drain_busy"}, 32'({busy, bist_en}), 32'd3);
            end
            @(posedge clk); n++;
            @(negedge clk);
        end
        start = 1'b0;
        chk({nm, "_latency"}, 32'(n), 32'd2561);
        chk({nm, "_busy_done"}, 32'(busy), 32'd0);
        chk({nm, "_pass"}, 32'(pass), 32'(ecnt == 0));
        chk({nm, "_fail_cnt"}, 32'(fail_cnt), 32'(ecnt));
        chk({nm, "_fail_addr"}, 32'(fail_addr), 32'(eaddr));
        chk({nm, "_fail_bits"}, 32'(fail_bits), 32'(ebits));
        alen = act_q.size() - idx0;
        chk({nm, "_ops"}, 32'(alen), 32'(exp_q.size()));
        mism = 0; nw = 0; nr = 0;
        for (int i = 0; i < alen; i++) begin
            if (i < exp_q.size() && act_q[idx0+i] != exp_q[i]) mism++;
            if (act_q[idx0+i][17]) nw++;
            if (act_q[idx0+i][16]) nr++;
        end
        chk({nm, "_trace"}, 32'(mism), 32'd0);
        chk({nm, "_wen"}, 32'(nw), 32'd1280);
        chk({nm, "_ren"}, 32'(nr), 32'd1280);
        chk({nm, "_e3_first"}, (alen > 5*N) ? 32'(act_q[idx0+5*N]) : 32'hDEAD, 32'(pack_op(0, 1, 255, 8'h00)));
        chk({nm, "_e3_second_rd"}, (alen > 5*N+2) ? 32'(act_q[idx0+5*N+2]) : 32'hDEAD, 32'(pack_op(0, 1, 254, 8'h00)));
        chk({nm, "_e5_last"}, (alen >= 10*N) ? 32'(act_q[idx0+10*N-1]) : 32'hDEAD, 32'(pack_op(0, 1, 255, 8'h00)));
        cnt_snap = fail_cnt;
        repeat (3) @(negedge clk);
        chk({nm, "_hold_done"}, 32'(done), 32'd1);
        chk({nm, "_hold_cnt"}, 32'(fail_cnt), 32'(cnt_snap));
    endtask

    initial begin
        int nf, a, b;
        march = '{"w0", "r0w1", "r1w0", "r0w1", "r1w0", "r0"};
        march_down = '{0, 0, 0, 1, 1, 0};
        clear_faults();
        rst = 1'b1; start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outs", 32'({busy, done, pass, bist_en, bist_men, bist_wen, bist_ren}), 32'd0);
        chk("rst_cnt", 32'(fail_cnt), 32'd0);
        chk("rst_addr_din", 32'({bist_addr, bist_din, fail_addr, fail_bits}), 32'd0);
        chk("rst_bm", 32'(bist_bm), 32'hFF);
        rst = 1'b0;

        run_test("clean", 0);

        clear_faults(); sa1m[8'h5A] = 8'h08;
        run_test("sa1", 0);
        chk("sa1_cnt3", 32'(fail_cnt), 32'd3);
        chk("sa1_addr", 32'(fail_addr), 32'h5A);
        chk("sa1_bits", 32'(fail_bits), 32'h08);

        clear_faults(); sa0m[8'hFF] = 8'h01;
        run_test("sa0", 0);
        chk("sa0_cnt2", 32'(fail_cnt), 32'd2);
        chk("sa0_addr", 32'(fail_addr), 32'hFF);
        chk("sa0_bits", 32'(fail_bits), 32'h01);

        clear_faults();
        run_test("rerun", 0);
        chk("rerun_pass", 32'(pass), 32'd1);

        run_test("hold", 2000);

        // Abort mid-run with reset, then a normal run.
        @(negedge clk); start = 1'b1;
        @(posedge clk);
        @(negedge clk); start = 1'b0;
        repeat (99) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("abort_outs", 32'({bist_en, busy, done, bist_men}), 32'd0);
        rst = 1'b0;
        run_test("post_rst", 0);

        for (int r = 0; r < 4; r++) begin
            clear_faults();
            nf = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) begin
                a = $urandom_range(0, N - 1);
                b = $urandom_range(0, DATA_W - 1);
                if ($urandom_range(0, 1) == 1) sa1m[a][b] = 1'b1;
                else                           sa0m[a][b] = 1'b1;
            end
            repeat ($urandom_range(0, 5)) @(posedge clk);
            run_test($sformatf("rnd%0d", r), ($urandom_range(0, 1) == 1) ? $urandom_range(1, 2500) : 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
